// File: rtl/micb_codec_writer_if.sv
// Request/status handshake between the mic-boost control stage (master)
// and the codec register writer (slave).
interface micb_codec_writer_if;
  logic Go;
  logic MICB_Power;
  logic Busy;
  logic Done;
  logic Ack_err;

  modport master (output Go, MICB_Power, input Busy, Done, Ack_err);
  modport slave  (input Go, MICB_Power, output Busy, Done, Ack_err);
endinterface

// File: rtl/micb_codec_writer.sv
// Writes the codec Analog Audio Path Control register over a 2-wire bus on each Go, MICBOOST = MICB_Power.
// Optional MICB_ACK_CHECK_EN: a NACKed byte aborts to STOP and sets the sticky Ack_err flag.
module micb_codec_writer #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          I2C_FREQ = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h34,
  parameter logic [6:0]  REG_ADDR = 7'h04,
  parameter logic [8:0]  REG_BASE = 9'h014
) (
  input  logic               Clk,
  input  logic               Rst_n,
  micb_codec_writer_if.slave bus,
  output logic               I2C_SCLK,
  inout  wire                I2C_SDAT
);
  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    q_reg, q_next;
  logic [4:0]    bit_reg, bit_next;
  logic          micb_reg, micb_next;
  logic          pend_reg, pend_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          sclk_next;
  logic          sda_low_reg, sda_low_next;
  logic          abort;
  logic          tick;
  logic [23:0]   frame;

  // Whole frame as one MSB-first vector: device byte, {reg addr, D[8]}, D[7:0]
  assign frame = {DEV_ADDR, REG_ADDR, REG_BASE[8:1], micb_reg};
  assign tick  = busy_reg && (cnt_reg == CW'(DIV - 1));

`ifdef MICB_ACK_CHECK_EN
  logic       ack_err_reg, ack_err_next;
  logic [1:0] sda_sync_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sda_sync_reg <= 2'b11;
      ack_err_reg  <= 1'b0;
    end else begin
      sda_sync_reg <= {sda_sync_reg[0], I2C_SDAT};
      ack_err_reg  <= ack_err_next;
    end
  end

  assign abort       = ack_err_reg;
  assign bus.Ack_err = ack_err_reg;
`else
  assign abort       = 1'b0;
  assign bus.Ack_err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg <= '0;
    end else if (!busy_reg || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= S_IDLE;
      q_reg       <= 2'd0;
      bit_reg     <= 5'd23;
      micb_reg    <= 1'b0;
      pend_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      I2C_SCLK    <= 1'b1;
      sda_low_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      q_reg       <= q_next;
      bit_reg     <= bit_next;
      micb_reg    <= micb_next;
      pend_reg    <= pend_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      I2C_SCLK    <= sclk_next;
      sda_low_reg <= sda_low_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    bit_next   = bit_reg;
    micb_next  = micb_reg;
    pend_next  = pend_reg;
`ifdef MICB_ACK_CHECK_EN
    ack_err_next = ack_err_reg;
`endif
    if (bus.Go && state_reg != S_IDLE) pend_next = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (bus.Go || pend_reg) begin
          state_next = S_START;
          q_next     = 2'd0;
          bit_next   = 5'd23;
          micb_next  = bus.MICB_Power;
          pend_next  = 1'b0;
`ifdef MICB_ACK_CHECK_EN
          ack_err_next = 1'b0;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          q_next = q_reg + 2'd1;
          if (q_reg == 2'd3) state_next = S_BIT;
        end
      end
      S_BIT: begin
        if (tick) begin
          q_next = q_reg + 2'd1;
          if (q_reg == 2'd3) begin
            if (bit_reg[2:0] == 3'd0) state_next = S_ACK;
            else                      bit_next   = bit_reg - 5'd1;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          q_next = q_reg + 2'd1;
`ifdef MICB_ACK_CHECK_EN
          if (q_reg == 2'd2 && sda_sync_reg[1]) ack_err_next = 1'b1;
`endif
          if (q_reg == 2'd3) begin
            if (bit_reg == 5'd0 || abort) begin
              state_next = S_STOP;
            end else begin
              state_next = S_BIT;
              bit_next   = bit_reg - 5'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          q_next = q_reg + 2'd1;
          if (q_reg == 2'd3) state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Pin levels are decoded from the next state so they change on the same edge as the quarter
    sclk_next    = 1'b1;
    sda_low_next = 1'b0;
    case (state_next)
      S_START: begin
        sclk_next    = (q_next != 2'd3);
        sda_low_next = (q_next != 2'd0);
      end
      S_BIT: begin
        sclk_next    = (q_next == 2'd1) || (q_next == 2'd2);
        sda_low_next = !frame[bit_next];
      end
      S_ACK: sclk_next = (q_next == 2'd1) || (q_next == 2'd2);
      S_STOP: begin
        sclk_next    = (q_next != 2'd0);
        sda_low_next = (q_next <= 2'd1);
      end
      default: ;
    endcase

    busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next = (state_next == S_DONE);
  end

  assign bus.Busy = busy_reg;
  assign bus.Done = done_reg;
  assign I2C_SDAT = sda_low_reg ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_micb_codec_writer.sv
// Directed bench for micb_codec_writer: 2-wire slave/monitor model plus
// immediate-assertion checks of frame bytes, timing, handshake and reset behaviour.
module tb_micb_codec_writer;
  localparam int DIV   = 25;
  localparam int FRAME = 116 * DIV;
  localparam int NACKF = 44 * DIV;

  logic Clk = 1'b0;
  logic Rst_n;
  logic I2C_SCLK;
  wire  sda_b;
  logic slave_low = 1'b0;

  micb_codec_writer_if bus_if ();

  micb_codec_writer #(
    .CLK_FREQ(10_000_000),
    .I2C_FREQ(100_000)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .bus     (bus_if),
    .I2C_SCLK(I2C_SCLK),
    .I2C_SDAT(sda_b)
  );

  pullup (sda_b);
  assign sda_b = slave_low ? 1'b0 : 1'bz;

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Bus monitor and acking slave, sampled away from the DUT's active edge
  logic       prev_sclk = 1'b1;
  logic       prev_sda  = 1'b1;
  int         bitcnt = 0;
  int         nbytes = 0;
  int         starts = 0;
  int         stops  = 0;
  int         nack_sel = -1;
  logic [7:0] cur = 8'h00;
  logic [7:0] rx [0:2];

  always @(negedge Clk) begin
    if (I2C_SCLK && prev_sclk && prev_sda && !sda_b) begin
      starts++;
      bitcnt = 0;
      nbytes = 0;
    end else if (I2C_SCLK && prev_sclk && !prev_sda && sda_b) begin
      stops++;
      bitcnt    = 0;
      slave_low = 1'b0;
    end else if (I2C_SCLK && !prev_sclk) begin
      if (bitcnt == 8) begin
        bitcnt = 0;
      end else begin
        cur = {cur[6:0], sda_b};
        bitcnt++;
        if (bitcnt == 8) begin
          if (nbytes < 3) rx[nbytes] = cur;
          nbytes++;
        end
      end
    end else if (!I2C_SCLK && prev_sclk) begin
      slave_low = (bitcnt == 8) && (nbytes - 1 != nack_sel);
    end
    prev_sclk = I2C_SCLK;
    prev_sda  = sda_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo) === 1'b1 && (obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic pulse_go(input logic pwr);
    @(negedge Clk);
    bus_if.MICB_Power = pwr;
    bus_if.Go         = 1'b1;
    @(negedge Clk);
    bus_if.Go         = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int busy_low);
    cyc      = 0;
    busy_low = 0;
    while (bus_if.Done !== 1'b1 && cyc < limit) begin
      if (bus_if.Busy !== 1'b1) busy_low++;
      @(negedge Clk);
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bl, bad, s0, p0, gap;
    Rst_n             = 1'b0;
    bus_if.Go         = 1'b0;
    bus_if.MICB_Power = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_sclk", I2C_SCLK, 1);
    chk("rst_sdat", sda_b, 1);
    chk("rst_busy", bus_if.Busy, 0);
    chk("rst_done", bus_if.Done, 0);
    chk("rst_ackerr", bus_if.Ack_err, 0);

    // Idle after reset release with no request
    Rst_n = 1'b1;
    bad   = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge Clk);
      if (I2C_SCLK !== 1'b1 || sda_b !== 1'b1 || bus_if.Busy !== 1'b0 ||
          bus_if.Done !== 1'b0 || bus_if.Ack_err !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    // Frame A: MICBOOST = 1
    s0 = starts; p0 = stops;
    pulse_go(1'b1);
    chk("a_busy_latency", bus_if.Busy, 1);
    wait_done(FRAME + 50, cyc, bl);
    chk_range("a_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("a_busy_low", bl, 0);
    chk("a_nbytes", nbytes, 3);
    chk("a_byte0", rx[0], 8'h34);
    chk("a_byte1", rx[1], 8'h08);
    chk("a_byte2", rx[2], 8'h15);
    chk("a_starts", starts - s0, 1);
    chk("a_stops", stops - p0, 1);
    chk("a_ackerr", bus_if.Ack_err, 0);
    chk("a_done_busy", bus_if.Busy, 0);
    @(negedge Clk);
    chk("a_done_single", bus_if.Done, 0);

    // Frame B: MICBOOST = 0, input changes after acceptance must not leak in
    pulse_go(1'b0);
    bus_if.MICB_Power = 1'b1;
    wait_done(FRAME + 50, cyc, bl);
    chk_range("b_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("b_busy_low", bl, 0);
    chk("b_byte2", rx[2], 8'h14);
    repeat (5) @(negedge Clk);

    // Second Go 1000 clocks into a frame is held pending
    pulse_go(1'b0);
    repeat (998) @(negedge Clk);
    pulse_go(1'b1);
    wait_done(FRAME, cyc, bl);
    chk_range("p1_done_latency", cyc, FRAME - 1000 - 2, FRAME - 1000 + 2);
    chk("p1_byte2", rx[2], 8'h14);
    gap = 0;
    while (bus_if.Busy !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge Clk);
    end
    chk("p_gap", gap, 2);
    wait_done(FRAME + 50, cyc, bl);
    chk_range("p2_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("p2_nbytes", nbytes, 3);
    chk("p2_byte1", rx[1], 8'h08);
    chk("p2_byte2", rx[2], 8'h15);
    repeat (5) @(negedge Clk);

    // Slave NACKs the device byte
    nack_sel = 0;
    pulse_go(1'b1);
    wait_done(FRAME + 50, cyc, bl);
    chk("n_byte0", rx[0], 8'h34);
`ifdef MICB_ACK_CHECK_EN
    chk_range("n_done_latency", cyc, NACKF - 2, NACKF + 2);
    chk("n_nbytes", nbytes, 1);
    chk("n_ackerr", bus_if.Ack_err, 1);
    repeat (50) @(negedge Clk);
    chk("n_ackerr_sticky", bus_if.Ack_err, 1);
    nack_sel = -1;
    pulse_go(1'b0);
    chk("n_ackerr_cleared", bus_if.Ack_err, 0);
    wait_done(FRAME + 50, cyc, bl);
    chk_range("n2_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("n2_ackerr", bus_if.Ack_err, 0);
`else
    chk_range("n_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("n_nbytes", nbytes, 3);
    chk("n_ackerr", bus_if.Ack_err, 0);
    nack_sel = -1;
`endif
    repeat (5) @(negedge Clk);

    // Reset in the middle of the device byte MSB (SCLK high, SDAT driven low) with a Go pending
    pulse_go(1'b1);
    repeat (6 * DIV) @(negedge Clk);
    bus_if.Go = 1'b1;
    @(negedge Clk);
    bus_if.Go = 1'b0;
    chk("r_pre_sclk", I2C_SCLK, 1);
    chk("r_pre_sdat", sda_b, 0);
    #1 Rst_n = 1'b0;
    #1;
    chk("r_sclk", I2C_SCLK, 1);
    chk("r_sdat", sda_b, 1);
    chk("r_busy", bus_if.Busy, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    bad   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (bus_if.Busy !== 1'b0) bad++;
    end
    chk("r_pending_cleared", bad, 0);
    s0 = starts; p0 = stops;
    pulse_go(1'b0);
    wait_done(FRAME + 50, cyc, bl);
    chk_range("r_done_latency", cyc, FRAME - 2, FRAME + 2);
    chk("r_nbytes", nbytes, 3);
    chk("r_byte0", rx[0], 8'h34);
    chk("r_byte2", rx[2], 8'h14);
    chk("r_starts", starts - s0, 1);
    chk("r_stops", stops - p0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
